regfile_wb_arbiter: RTL and testbench

//  Shares the single write port of the register bank (N x Bits, ports ptr_wr/data_wr/wr_en) between two

---
 rtl/regfile_wb_arbiter.sv | 103 ++++++++++
 tb/tb_regfile_wb_arbiter.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//   Shares the single write port of the register bank between two writeback
//   requesters (req0 = ALU, req1 = load) with strict round-robin alternation.
//   Writes to register 0 are accepted and silently dropped. A pending-write
//   scoreboard marks registers whose producer has issued but not yet written.
//
// Ports
//   clk, rst                 rising-edge clock, async active-low reset
//   reqN_valid/ptr/data      writeback request from requester N
//   reqN_ready               request accepted this cycle (combinational)
//   set_valid/set_ptr        issue stage marks a destination pending
//   wr_en/ptr_wr/data_wr     registered bank write port (latency 1 from grant)
//   pending[N]               registered scoreboard, bit 0 always 0
module regfile_wb_arbiter #(
  parameter int N    = 32,
  parameter int Bits = 64,
  localparam int PW  = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req0_valid,
  input  logic [PW-1:0]   req0_ptr,
  input  logic [Bits-1:0] req0_data,
  output logic            req0_ready,
  input  logic            req1_valid,
  input  logic [PW-1:0]   req1_ptr,
  input  logic [Bits-1:0] req1_data,
  output logic            req1_ready,
  input  logic            set_valid,
  input  logic [PW-1:0]   set_ptr,
  output logic            wr_en,
  output logic [PW-1:0]   ptr_wr,
  output logic [Bits-1:0] data_wr,
  output logic [N-1:0]    pending
);

  typedef struct packed {
    logic [PW-1:0]   ptr;
    logic [Bits-1:0] data;
  } wb_req_t;

  logic    prio;       // 0: req0 wins contention, 1: req1 wins
  logic    real0, real1, zero0, zero1;
  logic    gnt0, gnt1, gnt_any;
  wb_req_t gnt_req;

  // Zero-pointer requests are acknowledged but never reach the bank, so they
  // take no part in arbitration and do not disturb prio.
  assign zero0 = req0_valid && (req0_ptr == '0);
  assign zero1 = req1_valid && (req1_ptr == '0);
  assign real0 = req0_valid && (req0_ptr != '0);
  assign real1 = req1_valid && (req1_ptr != '0);

  assign gnt0    = real0 && (!real1 || !prio);
  assign gnt1    = real1 && (!real0 ||  prio);
  assign gnt_any = gnt0 || gnt1;

  // Nothing is accepted while reset is asserted; requesters re-present after.
  assign req0_ready = rst && (zero0 || gnt0);
  assign req1_ready = rst && (zero1 || gnt1);

  always_comb begin
    gnt_req = '{ptr: req1_ptr, data: req1_data};
    if (gnt0) gnt_req = '{ptr: req0_ptr, data: req0_data};
  end

  // Write stage and round-robin pointer. ptr_wr/data_wr hold when idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_en   <= 1'b0;
      ptr_wr  <= '0;
      data_wr <= '0;
      prio    <= 1'b0;
    end else begin
      wr_en <= gnt_any;
      if (gnt_any) begin
        ptr_wr  <= gnt_req.ptr;
        data_wr <= gnt_req.data;
        prio    <= gnt0;          // favour the requester that just lost
      end
    end
  end

  // Scoreboard: one flop per architectural register except r0. The clear is
  // taken at grant time so the bit falls in the same cycle wr_en rises; a
  // simultaneous set (new producer) overrides the clear.
  logic [N-1:1] pend_q;

  for (genvar gi = 1; gi < N; gi++) begin : g_sb
    logic set_hit, clr_hit;
    assign set_hit = set_valid && (set_ptr == PW'(gi));
    assign clr_hit = gnt_any && (gnt_req.ptr == PW'(gi));

    always_ff @(posedge clk or negedge rst) begin
      if (!rst)         pend_q[gi] <= 1'b0;
      else if (set_hit) pend_q[gi] <= 1'b1;
      else if (clr_hit) pend_q[gi] <= 1'b0;
    end
  end

  assign pending = {pend_q, 1'b0};

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;
  localparam int N = 32, Bits = 64, PW = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic            req0_valid, req1_valid, set_valid;
  logic [PW-1:0]   req0_ptr, req1_ptr, set_ptr;
  logic [Bits-1:0] req0_data, req1_data;
  logic            req0_ready, req1_ready, wr_en;
  logic [PW-1:0]   ptr_wr;
  logic [Bits-1:0] data_wr;
  logic [N-1:0]    pending;

  int checks = 0, failures = 0;

  regfile_wb_arbiter #(.N(N), .Bits(Bits)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ptr(req0_ptr), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_ptr(req1_ptr), .req1_data(req1_data), .req1_ready(req1_ready),
    .set_valid(set_valid), .set_ptr(set_ptr),
    .wr_en(wr_en), .ptr_wr(ptr_wr), .data_wr(data_wr), .pending(pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int exp_ptr [8] = '{1, 9, 2, 10, 3, 11, 4, 12};

  initial begin
    int i0, i1;
    rst = 1'b0;
    req0_valid = 1'b1; req0_ptr = 5'd2; req0_data = 64'h20;
    req1_valid = 1'b1; req1_ptr = 5'd3; req1_data = 64'h30;
    set_valid = 1'b0;  set_ptr = '0;

    // 1: reset held two cycles with both valids up
    tick(); tick();
    chk("rst_wr_en", wr_en, 0);
    chk("rst_pending", pending, 0);
    chk("rst_rdy0", req0_ready, 0);
    chk("rst_rdy1", req1_ready, 0);
    chk("rst_ptr_wr", ptr_wr, 0);
    chk("rst_data_wr", data_wr, 0);
    rst = 1'b1; #1;
    chk("rel_rdy0", req0_ready, 1);
    chk("rel_rdy1", req1_ready, 0);
    tick();
    req0_valid = 1'b0; #1;
    chk("rel_wr_en", wr_en, 1);
    chk("rel_ptr", ptr_wr, 2);
    chk("rel_data", data_wr, 64'h20);
    chk("rel_rdy1_next", req1_ready, 1);
    tick();
    req1_valid = 1'b0;
    chk("rel_ptr2", ptr_wr, 3);
    tick();
    chk("rel_idle", wr_en, 0);
    chk("rel_hold_ptr", ptr_wr, 3);          // prio now 0

    // 2: single requester
    req0_valid = 1'b1; req0_ptr = 5'd5; req0_data = 64'hAA; #1;
    chk("single_rdy", req0_ready, 1);
    tick();
    req0_valid = 1'b0;
    chk("single_wr_en", wr_en, 1);
    chk("single_ptr", ptr_wr, 5);
    chk("single_data", data_wr, 64'hAA);
    tick();
    chk("single_idle", wr_en, 0);            // prio now 1

    // 4: zero drop alongside a real request
    req0_valid = 1'b1; req0_ptr = 5'd0; req0_data = 64'hDEAD;
    req1_valid = 1'b1; req1_ptr = 5'd7; req1_data = 64'h77; #1;
    chk("zero_rdy0", req0_ready, 1);
    chk("zero_rdy1", req1_ready, 1);
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk("zero_wr_en", wr_en, 1);
    chk("zero_ptr", ptr_wr, 7);
    chk("zero_data", data_wr, 64'h77);
    // lone zero drop: acknowledged, no write, prio (now 0) must not move
    req0_valid = 1'b1; req0_ptr = 5'd0; #1;
    chk("zero_only_rdy", req0_ready, 1);
    tick();
    req0_valid = 1'b0;
    chk("zero_only_no_wr", wr_en, 0);
    chk("zero_only_ptr_hold", ptr_wr, 7);

    // 3: contention, req0 first because prio stayed 0
    i0 = 0; i1 = 0;
    for (int k = 0; k < 8; k++) begin
      req0_valid = (i0 < 4); req0_ptr = PW'(1 + i0); req0_data = 64'(16'h100 + i0);
      req1_valid = (i1 < 4); req1_ptr = PW'(9 + i1); req1_data = 64'(16'h200 + i1);
      #1;
      chk($sformatf("cont_rdy0_%0d", k), req0_ready, (k % 2 == 0));
      chk($sformatf("cont_rdy1_%0d", k), req1_ready, (k % 2 == 1));
      tick();
      chk($sformatf("cont_wr_en_%0d", k), wr_en, 1);
      chk($sformatf("cont_ptr_%0d", k), ptr_wr, exp_ptr[k]);
      if (k % 2 == 0) i0++; else i1++;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk("cont_last_data", data_wr, 64'h203);
    tick();
    chk("cont_idle", wr_en, 0);              // prio now 0

    // 5: scoreboard
    set_valid = 1'b1; set_ptr = 5'd3;
    tick();
    set_valid = 1'b0;
    chk("sb_set", pending, 32'h8);
    req1_valid = 1'b1; req1_ptr = 5'd3; req1_data = 64'h33; #1;
    chk("sb_rdy1", req1_ready, 1);
    tick();
    req1_valid = 1'b0;
    chk("sb_clr_wr_en", wr_en, 1);
    chk("sb_clr", pending, 32'h0);
    set_valid = 1'b1; set_ptr = 5'd3;
    tick();
    chk("sb_reset_bit", pending, 32'h8);
    req0_valid = 1'b1; req0_ptr = 5'd3; req0_data = 64'h44;  // set and clear together
    tick();
    req0_valid = 1'b0; set_valid = 1'b0;
    chk("sb_race_wr_ptr", ptr_wr, 3);
    chk("sb_set_wins", pending, 32'h8);
    set_valid = 1'b1; set_ptr = 5'd0;
    tick();
    set_valid = 1'b0;
    chk("sb_set_zero", pending, 32'h8);
    req1_valid = 1'b1; req1_ptr = 5'd3; req1_data = 64'h55;  // prio 1
    tick();
    req1_valid = 1'b0;
    chk("sb_final_clr", pending, 32'h0);     // prio now 0

    // 6: same-pointer race, then async reset mid-sequence
    req0_valid = 1'b1; req0_ptr = 5'd6; req0_data = 64'h1;
    req1_valid = 1'b1; req1_ptr = 5'd6; req1_data = 64'h2;
    set_valid = 1'b1; set_ptr = 5'd9; #1;
    chk("race_rdy0", req0_ready, 1);
    chk("race_rdy1", req1_ready, 0);
    tick();
    req0_valid = 1'b0; set_valid = 1'b0; #1;
    chk("race_first_data", data_wr, 64'h1);
    chk("race_rdy1_next", req1_ready, 1);
    tick();
    req1_valid = 1'b0;
    chk("race_second_ptr", ptr_wr, 6);
    chk("race_second_data", data_wr, 64'h2);
    chk("race_pending", pending, 32'h200);
    req0_valid = 1'b1; req0_ptr = 5'd4; req0_data = 64'h99;
    tick();
    chk("pre_rst_wr_en", wr_en, 1);
    #2 rst = 1'b0; #1;
    chk("async_wr_en", wr_en, 0);
    chk("async_pending", pending, 0);
    chk("async_ptr", ptr_wr, 0);
    chk("async_rdy0", req0_ready, 0);
    tick();
    rst = 1'b1;
    req0_valid = 1'b0;
    tick();
    chk("post_rst_idle", wr_en, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "timeout");
  end
endmodule
